// File: rtl/pipe_if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: redirect select codes,
// the nop word, the fetch FSM state encoding and a word-alignment helper.
package pipe_if_fetch_pkg;

  localparam int unsigned XLEN = 32;

  // Decode redirect select
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  // Instruction presented to IF/ID when no real fetch completes
  localparam logic [XLEN-1:0] NOP_INS = 32'h0000_0000;

  // Fetch FSM: REQ drives the memory, HOLD parks a fetched word during a stall
  typedef enum logic {
    FETCH_REQ  = 1'b0,
    FETCH_HOLD = 1'b1
  } fetch_state_e;

  // Force a byte address onto a word boundary
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_if_fetch_mux4x32.sv
// mux4x32: 4-to-1, 32-bit combinational selector cell.
//   a0..a3 : data inputs
//   s      : select (00 -> a0 ... 11 -> a3)
//   y      : selected word
module mux4x32 (
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [1:0]  s,
  output logic [31:0] y
);

  always_comb begin
    y = a0;
    case (s)
      2'b00:   y = a0;
      2'b01:   y = a1;
      2'b10:   y = a2;
      2'b11:   y = a3;
      default: y = a0;
    endcase
  end

endmodule

// File: rtl/pipe_if_fetch.sv
// pipe_if_fetch: instruction-fetch stage, producer side of IF/ID.
// Holds the PC, fetches from a variable-latency memory over req/ready, and
// applies decode redirects with delay-slot semantics.
//   clk, clr            : clock, asynchronous active-high reset
//   nostall             : IF/ID write enable from decode
//   pcsource            : redirect select (seq / branch / jr / j)
//   bpc, jpc, rpc       : branch, jump and jr targets
//   imem_req, imem_addr : fetch request and address (= pc)
//   imem_ready          : memory accepts, imem_rdata valid same cycle
//   imem_rdata          : fetched instruction word
//   pc4, ins, ins_vld   : pc+4, instruction and its valid flag toward IF/ID
module pipe_if_fetch
  import pipe_if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        nostall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc4,
  output logic [31:0] ins,
  output logic        ins_vld
);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   mux_y;
  logic [XLEN-1:0]   tgt;
  logic [XLEN-1:0]   npc;
  logic [XLEN-1:0]   redir_pc;
  logic              redir_vld;
  logic [XLEN-1:0]   hold_ins;
  logic              fetch_complete;
  logic              adv;
  logic              redirect_now;

  // Sequential address; wraps naturally at 2^32
  assign pc_plus4  = pc + XLEN'(4);
  assign pc4       = pc_plus4;
  assign imem_addr = pc;

  // Target select through the shared 4:1 cell
  mux4x32 u_npc_mux (
    .a0 (pc_plus4),
    .a1 (bpc),
    .a2 (rpc),
    .a3 (jpc),
    .s  (pcsource),
    .y  (mux_y)
  );

  assign tgt = align_word(mux_y);

  // Decode operands may be unresolved during a stall, so pcsource only
  // counts while IF/ID is actually latching.
  assign redirect_now = (pcsource != PCSRC_SEQ) && nostall;

  assign adv = fetch_complete && nostall;

  // Live redirect beats a parked one; a parked one beats sequential flow
  always_comb begin
    npc = pc_plus4;
    if (redirect_now) begin
      npc = tgt;
    end else if (redir_vld) begin
      npc = redir_pc;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= FETCH_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: park the word in HOLD when it lands during a stall
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_REQ: begin
        if (imem_req && imem_ready && !nostall) begin
          state_nxt = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (nostall) begin
          state_nxt = FETCH_REQ;
        end
      end
      default: state_nxt = FETCH_REQ;
    endcase
  end

  // FSM outputs; the request drops with clr without waiting for a clock
  always_comb begin
    imem_req       = 1'b0;
    ins            = NOP_INS;
    ins_vld        = 1'b0;
    fetch_complete = 1'b0;
    case (state)
      FETCH_REQ: begin
        imem_req = !clr;
        if (!clr && imem_ready) begin
          ins            = imem_rdata;
          ins_vld        = 1'b1;
          fetch_complete = 1'b1;
        end
      end
      FETCH_HOLD: begin
        ins            = hold_ins;
        ins_vld        = 1'b1;
        fetch_complete = 1'b1;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  // PC advances only when the current word is handed to IF/ID
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc <= RESET_PC;
    end else if (adv) begin
      pc <= npc;
    end
  end

  // Keep a redirect alive while its delay-slot fetch is still outstanding
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      redir_vld <= 1'b0;
      redir_pc  <= '0;
    end else if (adv) begin
      redir_vld <= 1'b0;
    end else if (redirect_now) begin
      redir_vld <= 1'b1;
      redir_pc  <= tgt;
    end
  end

  // Word fetched during a stall, replayed until decode takes it
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hold_ins <= NOP_INS;
    end else if (state == FETCH_REQ && imem_req && imem_ready && !nostall) begin
      hold_ins <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_pipe_if_fetch.sv
// Directed, table-driven bench for pipe_if_fetch.
module tb_pipe_if_fetch;

  logic        clk;
  logic        clr;
  logic        nostall;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] rpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc4;
  logic [31:0] ins;
  logic        ins_vld;

  int checks;
  int errors;

  typedef struct {
    logic        ns;
    logic [1:0]  ps;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_ins;
    logic        e_vld;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs [0:39];
  int   nvec;

  pipe_if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .clr        (clr),
    .nostall    (nostall),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .jpc        (jpc),
    .rpc        (rpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc4        (pc4),
    .ins        (ins),
    .ins_vld    (ins_vld)
  );

  // Memory returns addr|1 when requested, garbage otherwise
  assign imem_rdata = imem_req ? (imem_addr | 32'h1) : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic ns, input logic [1:0] ps, input logic [31:0] b,
                     input logic [31:0] j, input logic [31:0] r, input logic rdy,
                     input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_ins,
                     input logic e_vld, input logic [31:0] e_pc4);
    vecs[nvec].ns     = ns;
    vecs[nvec].ps     = ps;
    vecs[nvec].bpc    = b;
    vecs[nvec].jpc    = j;
    vecs[nvec].rpc    = r;
    vecs[nvec].rdy    = rdy;
    vecs[nvec].e_req  = e_req;
    vecs[nvec].e_addr = e_addr;
    vecs[nvec].e_ins  = e_ins;
    vecs[nvec].e_vld  = e_vld;
    vecs[nvec].e_pc4  = e_pc4;
    nvec++;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    nvec     = 0;
    clr      = 1'b1;
    nostall  = 1'b1;
    pcsource = 2'b00;
    bpc      = '0;
    jpc      = '0;
    rpc      = '0;
    imem_ready = 1'b1;

    //   ns ps     bpc           jpc           rpc           rdy  req addr          ins           vld pc4
    // sequential, zero wait
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_0000, 32'h0000_0001, 1, 32'h0000_0004);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_0004, 32'h0000_0005, 1, 32'h0000_0008);
    // three wait cycles at pc=8
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        0,   1, 32'h0000_0008, 32'h0000_0000, 0, 32'h0000_000C);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        0,   1, 32'h0000_0008, 32'h0000_0000, 0, 32'h0000_000C);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        0,   1, 32'h0000_0008, 32'h0000_0000, 0, 32'h0000_000C);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_0008, 32'h0000_0009, 1, 32'h0000_000C);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_000C, 32'h0000_000D, 1, 32'h0000_0010);
    // load-use stall for 2 cycles at pc=10; redirect ignored while stalled
    add(0, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_0010, 32'h0000_0011, 1, 32'h0000_0014);
    add(0, 2'b11, 32'h0,        32'h0000_0300, 32'h0,       1,   0, 32'h0000_0010, 32'h0000_0011, 1, 32'h0000_0014);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   0, 32'h0000_0010, 32'h0000_0011, 1, 32'h0000_0014);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_0014, 32'h0000_0015, 1, 32'h0000_0018);
    // branch in ID while delay slot 18 is fetched; target low bits masked
    add(1, 2'b01, 32'h0000_0043, 32'h0,       32'h0,        1,   1, 32'h0000_0018, 32'h0000_0019, 1, 32'h0000_001C);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_0040, 32'h0000_0041, 1, 32'h0000_0044);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_0044, 32'h0000_0045, 1, 32'h0000_0048);
    // pending jump captured while delay slot 48 waits two cycles
    add(1, 2'b11, 32'h0,        32'h0000_0200, 32'h0,       0,   1, 32'h0000_0048, 32'h0000_0000, 0, 32'h0000_004C);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        0,   1, 32'h0000_0048, 32'h0000_0000, 0, 32'h0000_004C);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_0048, 32'h0000_0049, 1, 32'h0000_004C);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_0200, 32'h0000_0201, 1, 32'h0000_0204);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_0204, 32'h0000_0205, 1, 32'h0000_0208);
    // jr with misaligned register value
    add(1, 2'b10, 32'h0,        32'h0,        32'h0000_1002, 1,  1, 32'h0000_0208, 32'h0000_0209, 1, 32'h0000_020C);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_1000, 32'h0000_1001, 1, 32'h0000_1004);
    // stall into HOLD, then branch taken as HOLD releases
    add(0, 2'b01, 32'h0000_0500, 32'h0,       32'h0,        1,   1, 32'h0000_1004, 32'h0000_1005, 1, 32'h0000_1008);
    add(1, 2'b01, 32'h0000_0500, 32'h0,       32'h0,        1,   0, 32'h0000_1004, 32'h0000_1005, 1, 32'h0000_1008);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_0500, 32'h0000_0501, 1, 32'h0000_0504);
    // jump to top of address space, pc+4 wraps to 0
    add(1, 2'b11, 32'h0,        32'hFFFF_FFFC, 32'h0,       1,   1, 32'h0000_0504, 32'h0000_0505, 1, 32'h0000_0508);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 1, 32'h0000_0000);
    // branch parked, then a second redirect arrives: live one wins, parked cleared
    add(1, 2'b01, 32'h0000_0600, 32'h0,       32'h0,        0,   1, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0004);
    add(1, 2'b11, 32'h0,        32'h0000_0700, 32'h0,       1,   1, 32'h0000_0000, 32'h0000_0001, 1, 32'h0000_0004);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        1,   1, 32'h0000_0700, 32'h0000_0701, 1, 32'h0000_0704);
    add(1, 2'b11, 32'h0,        32'h0000_0030, 32'h0,       1,   1, 32'h0000_0704, 32'h0000_0705, 1, 32'h0000_0708);
    add(1, 2'b00, 32'h0,        32'h0,        32'h0,        0,   1, 32'h0000_0030, 32'h0000_0000, 0, 32'h0000_0034);

    // reset state
    #1;
    chk("rst_req",  -1, 32'(imem_req), 32'h0);
    chk("rst_vld",  -1, 32'(ins_vld),  32'h0);
    chk("rst_ins",  -1, ins,           32'h0);
    chk("rst_addr", -1, imem_addr,     32'h0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      nostall    = vecs[i].ns;
      pcsource   = vecs[i].ps;
      bpc        = vecs[i].bpc;
      jpc        = vecs[i].jpc;
      rpc        = vecs[i].rpc;
      imem_ready = vecs[i].rdy;
      #1;
      chk("req",  i, 32'(imem_req), 32'(vecs[i].e_req));
      chk("addr", i, imem_addr,     vecs[i].e_addr);
      chk("ins",  i, ins,           vecs[i].e_ins);
      chk("vld",  i, 32'(ins_vld),  32'(vecs[i].e_vld));
      chk("pc4",  i, pc4,           vecs[i].e_pc4);
      @(negedge clk);
    end

    // asynchronous reset while the fetch at 0x30 is still waiting
    nostall    = 1'b1;
    pcsource   = 2'b00;
    imem_ready = 1'b0;
    #1;
    chk("wait_addr", 100, imem_addr,     32'h0000_0030);
    chk("wait_req",  100, 32'(imem_req), 32'h1);
    #1;
    imem_ready = 1'b1;
    clr = 1'b1;
    #1;
    chk("arst_req",  101, 32'(imem_req), 32'h0);
    chk("arst_vld",  101, 32'(ins_vld),  32'h0);
    chk("arst_ins",  101, ins,           32'h0);
    chk("arst_addr", 101, imem_addr,     32'h0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("post_addr", 102, imem_addr,     32'h0);
    chk("post_req",  102, 32'(imem_req), 32'h1);
    chk("post_ins",  102, ins,           32'h0000_0001);
    @(negedge clk);
    #1;
    chk("post_addr2", 103, imem_addr,    32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
